regfile_seq: RTL and testbench
==============================

REGFILE_SEQ -- requirements
Module: regfile_seq

Interface
REQ-001 The block SHALL have parameter DW, default 16: data width of the register-file bus.
REQ-002 The block SHALL have parameter NREQ, default 2: number of requesters; requester 0 is EU and requester 1 is BIU.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port req, input, NREQ bits: per-requester access request.
REQ-006 The block SHALL have port we, input, NREQ bits: per-requester 1 = write, 0 = read.
REQ-007 The block SHALL have port reg_id, input, 5*NREQ bits: per-requester register code, 0..16 = AX,BX,CX,DX,AH,BH,CH,DH,AL,BL,CL,DL,SP,BP,SI,DI,IP.
REQ-008 The block SHALL have port hi, input, NREQ bits: per-requester byte lane; 1 = 8-bit data on bus bits [15:8].
REQ-009 The block SHALL have port wdata, input, DW*NREQ bits: per-requester write data.
REQ-010 The block SHALL have port ack, output, NREQ bits: one-cycle completion pulse per requester.
REQ-011 The block SHALL have port err, output, 1 bit: valid with ack; 1 = illegal reg_id.
REQ-012 The block SHALL have port rdata, output, DW bits: read result, valid in the ack cycle and held until the next ack.
REQ-013 The block SHALL have the following register-file side ports:
- rf_data, output, DW: write data to the register file.
- rf_re, output, 1: read strobe.
- rf_we, output, 1: write strobe.
- rf_wb, output, 1: byte-lane select.
- rf_sel, output, 17: one-hot select, AX at the MSB, IP at the LSB.
- rf_rout, input, DW: register-file read data.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, SETUP, STROBE and DONE.
REQ-015 In IDLE, if any req is high, the block SHALL latch the granted index and that requester's we, reg_id, hi and wdata, then go to SETUP; otherwise it SHALL stay in IDLE.
REQ-016 In SETUP, rf_sel, rf_wb and rf_data SHALL be driven from the latched fields with both strobes low; the FSM SHALL go to STROBE next cycle.
REQ-017 In STROBE, exactly one of rf_we or rf_re SHALL be high for one cycle, per the latched we; rf_sel, rf_wb and rf_data SHALL stay stable.
REQ-018 In DONE, the strobes SHALL be low, ack[grant] SHALL pulse, rdata SHALL capture rf_rout on reads (unchanged on writes), and the FSM SHALL return to IDLE.
REQ-019 Latency SHALL be fixed: ack is asserted 3 cycles after the edge that samples req in IDLE; throughput is one access per 4 cycles.
REQ-020 Requesters SHALL hold req and their fields until ack; a req still high in the IDLE cycle after ack SHALL be treated as a new access.
REQ-021 rf_sel SHALL equal 17'b1 << (16 - reg_id), and SHALL be all-zero in IDLE and DONE.
REQ-022 A reg_id of 17..31 SHALL produce no strobe and no rf_sel bit, and SHALL give ack with err = 1 in DONE at the same latency; rdata SHALL be unchanged.
REQ-023 Without REGSEQ_RR_EN, simultaneous requests SHALL be granted at fixed priority with index 0 (EU) winning.
REQ-024 A request arriving in any non-IDLE state SHALL wait; it SHALL NOT be dropped and SHALL NOT preempt the access in progress.

Reset
REQ-025 On reset, at any state including mid-STROBE, the block SHALL immediately force: FSM = IDLE; ack, err, rf_re, rf_we, rf_wb = 0; rf_sel = 0; rf_data = 0; rdata = 0; round-robin pointer = 0.
REQ-026 No ack SHALL be issued for an access interrupted by reset.

Configuration
REQ-027 With REGSEQ_RR_EN defined, arbitration SHALL be round-robin: the requester granted last has lowest priority on the next contention, and the pointer updates only on grant.
REQ-028 Without REGSEQ_RR_EN, arbitration SHALL be fixed priority per REQ-023, and the pointer logic SHALL be absent.

Structure
REQ-029 Package regseq_pkg SHALL hold the FSM state enum, the reg_id constants (ID_AX = 0 .. ID_IP = 16), NUM_REGS = 17 and the strobe/phase cycle constants.
REQ-030 The arbiter SHALL be a separate sub-module, regseq_arb, instantiated once: NREQ req bits in, one-hot grant out, plus the pointer under REGSEQ_RR_EN.

Verification
REQ-031 The bench SHALL cover: EU write, reg_id = 0 (AX), wdata = 16'h1234 → rf_sel = 17'h10000, rf_we high exactly one cycle, ack[0] 3 cycles after sampling, err = 0.
REQ-032 The bench SHALL cover: BIU read of IP (reg_id = 16) with rf_rout = 16'hBEEF → rf_re one pulse, rf_sel = 17'h00001, rdata = 16'hBEEF with ack[1].
REQ-033 The bench SHALL cover: EU and BIU requesting in the same cycle, held → fixed priority gives EU then BIU; under REGSEQ_RR_EN, back-to-back contention alternates 0, 1, 0, 1.
REQ-034 The bench SHALL cover: reg_id = 20 → no rf_re/rf_we pulse, rf_sel = 0, ack with err = 1, rdata unchanged.
REQ-035 The bench SHALL cover: AH write, hi = 1, wdata = 16'hAB00 → rf_wb = 1, rf_sel = 17'h01000 during SETUP and STROBE.
REQ-036 The bench SHALL cover: reset asserted during STROBE → all outputs 0 in the same cycle, no ack, and a new request after release completes normally.

Source files
------------

// File: rtl/regseq_pkg.sv
// Shared definitions for the register-file access sequencer: FSM states,
// register codes, phase timing constants and the select decoder.
package regseq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_DONE
  } state_t;

  localparam int NUM_REGS = 17;

  localparam logic [4:0] ID_AX = 5'd0;
  localparam logic [4:0] ID_BX = 5'd1;
  localparam logic [4:0] ID_CX = 5'd2;
  localparam logic [4:0] ID_DX = 5'd3;
  localparam logic [4:0] ID_AH = 5'd4;
  localparam logic [4:0] ID_BH = 5'd5;
  localparam logic [4:0] ID_CH = 5'd6;
  localparam logic [4:0] ID_DH = 5'd7;
  localparam logic [4:0] ID_AL = 5'd8;
  localparam logic [4:0] ID_BL = 5'd9;
  localparam logic [4:0] ID_CL = 5'd10;
  localparam logic [4:0] ID_DL = 5'd11;
  localparam logic [4:0] ID_SP = 5'd12;
  localparam logic [4:0] ID_BP = 5'd13;
  localparam logic [4:0] ID_SI = 5'd14;
  localparam logic [4:0] ID_DI = 5'd15;
  localparam logic [4:0] ID_IP = 5'd16;

  // Phase timing: one setup cycle, one strobe cycle, ack in the third cycle
  // after the sampling edge, one access every four cycles.
  localparam int SETUP_CYCLES  = 1;
  localparam int STROBE_CYCLES = 1;
  localparam int ACK_LATENCY   = 3;
  localparam int ACCESS_CYCLES = 4;

  // Codes above IP select nothing and are reported through err.
  function automatic logic id_legal(input logic [4:0] id);
    return id <= ID_IP;
  endfunction

  // One-hot register select, AX at the MSB down to IP at the LSB.
  function automatic logic [NUM_REGS-1:0] sel_onehot(input logic [4:0] id);
    logic [NUM_REGS-1:0] s;
    s = '0;
    if (id_legal(id)) s[ID_IP - id] = 1'b1;
    return s;
  endfunction

endpackage

// File: rtl/regseq_arb.sv
// Requester arbiter: one-hot grant from the request vector.
// REGSEQ_RR_EN defined   : round-robin, last granted requester goes last.
// REGSEQ_RR_EN undefined : fixed priority, lowest index wins, no state.
module regseq_arb #(
  parameter int NREQ = 2
) (
`ifdef REGSEQ_RR_EN
  input  logic            clk,
  input  logic            reset,
  input  logic            i_take,
`endif
  input  logic [NREQ-1:0] i_req,
  output logic [NREQ-1:0] o_grant
);

`ifdef REGSEQ_RR_EN
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_next_ptr;
  logic          w_found;

  // Search from the pointer upward; the winner's successor becomes the next pointer.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    o_grant    = '0;
    w_next_ptr = r_ptr;
    w_found    = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (int'(r_ptr) + k) % NREQ;
      if (!w_found && i_req[idx]) begin
        o_grant[idx] = 1'b1;
        w_next_ptr   = PW'((idx + 1) % NREQ);
        w_found      = 1'b1;
      end
    end
  end

  // Pointer advances only when the sequencer actually takes a grant.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses <= so every register sees pre-edge values.
    if (reset)       r_ptr <= '0;
    else if (i_take) r_ptr <= w_next_ptr;
  end
`else
  // Fixed priority: scanning downward leaves the lowest requesting index.
  always_comb begin
    o_grant = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_grant    = '0;
        o_grant[i] = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/regfile_seq.sv
// Register-file access sequencer: arbitrates EU/BIU requests and runs each
// access as IDLE -> SETUP -> STROBE -> DONE with registered outputs.
// Optional round-robin arbitration is enabled by defining REGSEQ_RR_EN.
module regfile_seq
  import regseq_pkg::*;
#(
  parameter int DW   = 16,
  parameter int NREQ = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       we,
  input  logic [5*NREQ-1:0]     reg_id,
  input  logic [NREQ-1:0]       hi,
  input  logic [DW*NREQ-1:0]    wdata,
  output logic [NREQ-1:0]       ack,
  output logic                  err,
  output logic [DW-1:0]         rdata,
  output logic [DW-1:0]         rf_data,
  output logic                  rf_re,
  output logic                  rf_we,
  output logic                  rf_wb,
  output logic [NUM_REGS-1:0]   rf_sel,
  input  logic [DW-1:0]         rf_rout
);

  state_t            r_state;
  logic [NREQ-1:0]   r_grant;
  logic              r_we;
  logic              r_legal;

  logic [NREQ-1:0]   w_grant;
  logic              w_we;
  logic [4:0]        w_id;
  logic              w_hi;
  logic [DW-1:0]     w_wdata;

`ifdef REGSEQ_RR_EN
  logic              w_take;
  assign w_take = (r_state == ST_IDLE) && (|req);
`endif

  regseq_arb #(.NREQ(NREQ)) u_arb (
`ifdef REGSEQ_RR_EN
    .clk     (clk),
    .reset   (reset),
    .i_take  (w_take),
`endif
    .i_req   (req),
    .o_grant (w_grant)
  );

  // Select the granted requester's fields.
  always_comb begin
    w_we    = 1'b0;
    w_id    = '0;
    w_hi    = 1'b0;
    w_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_we    = we[i];
        w_id    = reg_id[5*i +: 5];
        w_hi    = hi[i];
        w_wdata = wdata[DW*i +: DW];
      end
    end
  end

  // Access FSM; register-file side and requester side outputs are registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_we    <= 1'b0;
      r_legal <= 1'b0;
      ack     <= '0;
      err     <= 1'b0;
      rdata   <= '0;
      rf_data <= '0;
      rf_re   <= 1'b0;
      rf_we   <= 1'b0;
      rf_wb   <= 1'b0;
      rf_sel  <= '0;
    end else begin
      ack <= '0;
      err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (|req) begin
            r_grant <= w_grant;
            r_we    <= w_we;
            r_legal <= id_legal(w_id);
            rf_sel  <= sel_onehot(w_id);
            rf_wb   <= w_hi;
            rf_data <= w_wdata;
            r_state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          // Illegal codes run the same timeline but never strobe.
          rf_we   <= r_legal & r_we;
          rf_re   <= r_legal & ~r_we;
          r_state <= ST_STROBE;
        end
        ST_STROBE: begin
          rf_we   <= 1'b0;
          rf_re   <= 1'b0;
          rf_wb   <= 1'b0;
          rf_sel  <= '0;
          rf_data <= '0;
          ack     <= r_grant;
          err     <= ~r_legal;
          if (r_legal && !r_we) rdata <= rf_rout;
          r_state <= ST_DONE;
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_seq.sv
// Directed self-checking bench for regfile_seq (default or REGSEQ_RR_EN build).
module tb_regfile_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  req = '0;
  logic [1:0]  we = '0;
  logic [9:0]  reg_id = '0;
  logic [1:0]  hi = '0;
  logic [31:0] wdata = '0;
  logic [1:0]  ack;
  logic        err;
  logic [15:0] rdata;
  logic [15:0] rf_data;
  logic        rf_re;
  logic        rf_we;
  logic        rf_wb;
  logic [16:0] rf_sel;
  logic [15:0] rf_rout = '0;

  int total = 0;
  int bad   = 0;

  regfile_seq #(.DW(16), .NREQ(2)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .we      (we),
    .reg_id  (reg_id),
    .hi      (hi),
    .wdata   (wdata),
    .ack     (ack),
    .err     (err),
    .rdata   (rdata),
    .rf_data (rf_data),
    .rf_re   (rf_re),
    .rf_we   (rf_we),
    .rf_wb   (rf_wb),
    .rf_sel  (rf_sel),
    .rf_rout (rf_rout)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Snapshot {rf_re, rf_we, rf_wb, rf_sel, ack, err}.
  function automatic logic [22:0] obs();
    return {rf_re, rf_we, rf_wb, rf_sel, ack, err};
  endfunction

  function automatic logic [22:0] ev(input logic re, input logic wr, input logic wb,
                                     input logic [16:0] sel, input logic [1:0] a,
                                     input logic e);
    return {re, wr, wb, sel, a, e};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic w, input logic [4:0] id,
                         input logic h, input logic [15:0] d);
    req[i]            = 1'b1;
    we[i]             = w;
    reg_id[5*i +: 5]  = id;
    hi[i]             = h;
    wdata[16*i +: 16] = d;
  endtask

  task automatic clr_req(input int i);
    req[i] = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    total++;
    if (obs() !== 23'h0 || rf_data !== 16'h0 || rdata !== 16'h0) begin
      bad++;
      $display("FAIL reset_state: got %h/%h/%h want 0", obs(), rf_data, rdata);
    end
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_eu_write();
    logic [22:0] e [4];
    e[0] = ev(0, 0, 0, 17'h10000, 2'b00, 0);
    e[1] = ev(0, 1, 0, 17'h10000, 2'b00, 0);
    e[2] = ev(0, 0, 0, 17'h00000, 2'b01, 0);
    e[3] = ev(0, 0, 0, 17'h00000, 2'b00, 0);
    set_req(0, 1'b1, 5'd0, 1'b0, 16'h1234);
    for (int c = 0; c < 4; c++) begin
      step();
      total++;
      if (obs() !== e[c]) begin
        bad++;
        $display("FAIL eu_write cyc%0d: got %h want %h", c, obs(), e[c]);
      end
      if (c < 2) begin
        total++;
        if (rf_data !== 16'h1234) begin
          bad++;
          $display("FAIL eu_write_data cyc%0d: got %h want 1234", c, rf_data);
        end
      end
      if (c == 2) clr_req(0);
    end
  endtask

  task automatic test_biu_read();
    logic [22:0] e [4];
    e[0] = ev(0, 0, 0, 17'h00001, 2'b00, 0);
    e[1] = ev(1, 0, 0, 17'h00001, 2'b00, 0);
    e[2] = ev(0, 0, 0, 17'h00000, 2'b10, 0);
    e[3] = ev(0, 0, 0, 17'h00000, 2'b00, 0);
    rf_rout = 16'hBEEF;
    set_req(1, 1'b0, 5'd16, 1'b0, 16'h0000);
    for (int c = 0; c < 4; c++) begin
      step();
      total++;
      if (obs() !== e[c]) begin
        bad++;
        $display("FAIL biu_read cyc%0d: got %h want %h", c, obs(), e[c]);
      end
      if (c >= 2) begin
        total++;
        if (rdata !== 16'hBEEF) begin
          bad++;
          $display("FAIL biu_read_rdata cyc%0d: got %h want beef", c, rdata);
        end
      end
      if (c == 2) clr_req(1);
    end
  endtask

  task automatic test_illegal_id();
    logic [22:0] e [4];
    e[0] = ev(0, 0, 0, 17'h00000, 2'b00, 0);
    e[1] = ev(0, 0, 0, 17'h00000, 2'b00, 0);
    e[2] = ev(0, 0, 0, 17'h00000, 2'b01, 1);
    e[3] = ev(0, 0, 0, 17'h00000, 2'b00, 0);
    rf_rout = 16'h0BAD;
    set_req(0, 1'b0, 5'd20, 1'b0, 16'h0000);
    for (int c = 0; c < 4; c++) begin
      step();
      total++;
      if (obs() !== e[c]) begin
        bad++;
        $display("FAIL illegal_id cyc%0d: got %h want %h", c, obs(), e[c]);
      end
      if (c == 2) begin
        total++;
        if (rdata !== 16'hBEEF) begin
          bad++;
          $display("FAIL illegal_rdata: got %h want beef", rdata);
        end
        clr_req(0);
      end
    end
  endtask

  task automatic test_byte_write();
    logic [22:0] e [4];
    e[0] = ev(0, 0, 1, 17'h01000, 2'b00, 0);
    e[1] = ev(0, 1, 1, 17'h01000, 2'b00, 0);
    e[2] = ev(0, 0, 0, 17'h00000, 2'b01, 0);
    e[3] = ev(0, 0, 0, 17'h00000, 2'b00, 0);
    set_req(0, 1'b1, 5'd4, 1'b1, 16'hAB00);
    for (int c = 0; c < 4; c++) begin
      step();
      total++;
      if (obs() !== e[c]) begin
        bad++;
        $display("FAIL byte_write cyc%0d: got %h want %h", c, obs(), e[c]);
      end
      if (c < 2) begin
        total++;
        if (rf_data !== 16'hAB00) begin
          bad++;
          $display("FAIL byte_write_data cyc%0d: got %h want ab00", c, rf_data);
        end
      end
      if (c == 2) clr_req(0);
    end
    hi = '0;
  endtask

  task automatic test_contention();
    logic [22:0] e [8];
    e[0] = ev(0, 0, 0, 17'h04000, 2'b00, 0);
    e[1] = ev(0, 1, 0, 17'h04000, 2'b00, 0);
    e[2] = ev(0, 0, 0, 17'h00000, 2'b01, 0);
    e[3] = ev(0, 0, 0, 17'h00000, 2'b00, 0);
    e[4] = ev(0, 0, 0, 17'h02000, 2'b00, 0);
    e[5] = ev(1, 0, 0, 17'h02000, 2'b00, 0);
    e[6] = ev(0, 0, 0, 17'h00000, 2'b10, 0);
    e[7] = ev(0, 0, 0, 17'h00000, 2'b00, 0);
    rf_rout = 16'h7777;
    set_req(0, 1'b1, 5'd2, 1'b0, 16'h5555);
    set_req(1, 1'b0, 5'd3, 1'b0, 16'h0000);
    for (int c = 0; c < 8; c++) begin
      step();
      total++;
      if (obs() !== e[c]) begin
        bad++;
        $display("FAIL contention cyc%0d: got %h want %h", c, obs(), e[c]);
      end
      if (c == 2) clr_req(0);
      if (c == 6) begin
        total++;
        if (rdata !== 16'h7777) begin
          bad++;
          $display("FAIL contention_rdata: got %h want 7777", rdata);
        end
        clr_req(1);
      end
    end
  endtask

  // Both requesters held for four accesses; grant order depends on the build.
  task automatic test_back_to_back();
    logic [1:0] exp_ack [4];
`ifdef REGSEQ_RR_EN
    exp_ack[0] = 2'b01; exp_ack[1] = 2'b10; exp_ack[2] = 2'b01; exp_ack[3] = 2'b10;
`else
    exp_ack[0] = 2'b01; exp_ack[1] = 2'b01; exp_ack[2] = 2'b01; exp_ack[3] = 2'b01;
`endif
    #2 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    set_req(0, 1'b1, 5'd0, 1'b0, 16'h0001);
    set_req(1, 1'b1, 5'd1, 1'b0, 16'h0002);
    for (int n = 0; n < 4; n++) begin
      step();
      step();
      step();
      total++;
      if (ack !== exp_ack[n] || err !== 1'b0) begin
        bad++;
        $display("FAIL back_to_back acc%0d: got ack=%b err=%b want ack=%b err=0",
                 n, ack, err, exp_ack[n]);
      end
      step();
    end
    clr_req(0);
    clr_req(1);
  endtask

  task automatic test_reset_mid_strobe();
    logic [22:0] e [4];
    set_req(0, 1'b1, 5'd13, 1'b0, 16'hCAFE);
    step();
    step();
    total++;
    if (obs() !== ev(1'b0, 1'b1, 1'b0, 17'h00008, 2'b00, 1'b0)) begin
      bad++;
      $display("FAIL rst_pre_strobe: got %h", obs());
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if (obs() !== 23'h0 || rf_data !== 16'h0 || rdata !== 16'h0) begin
      bad++;
      $display("FAIL rst_mid_strobe: got %h/%h/%h want 0", obs(), rf_data, rdata);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    clr_req(0);
    for (int c = 0; c < 3; c++) begin
      step();
      total++;
      if (obs() !== 23'h0) begin
        bad++;
        $display("FAIL rst_no_ack cyc%0d: got %h want 0", c, obs());
      end
    end
    e[0] = ev(0, 0, 0, 17'h00004, 2'b00, 0);
    e[1] = ev(1, 0, 0, 17'h00004, 2'b00, 0);
    e[2] = ev(0, 0, 0, 17'h00000, 2'b10, 0);
    e[3] = ev(0, 0, 0, 17'h00000, 2'b00, 0);
    rf_rout = 16'h1357;
    set_req(1, 1'b0, 5'd14, 1'b0, 16'h0000);
    for (int c = 0; c < 4; c++) begin
      step();
      total++;
      if (obs() !== e[c]) begin
        bad++;
        $display("FAIL rst_recover cyc%0d: got %h want %h", c, obs(), e[c]);
      end
      if (c == 2) begin
        total++;
        if (rdata !== 16'h1357) begin
          bad++;
          $display("FAIL rst_recover_rdata: got %h want 1357", rdata);
        end
        clr_req(1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_eu_write();
    test_biu_read();
    test_illegal_id();
    test_byte_write();
    test_contention();
    test_back_to_back();
    test_reset_mid_strobe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
